rx78_scanout: RTL and testbench



---
 rtl/rx78_scanout_if.sv | 19 +
 rtl/rx78_scanout.sv | 165 ++++++++++++++++
 tb/tb_rx78_scanout.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rx78_scanout_if.sv
// rx78_scanout_if: shared read port of the six VRAM planes.
// One byte address, six plane bytes returned one clk later.
interface rx78_scanout_if;
  logic [12:0] vaddr;
  logic [7:0]  fg1, fg2, fg3;
  logic [7:0]  bg1, bg2, bg3;

  modport master (
    output vaddr,
    input  fg1, fg2, fg3,
    input  bg1, bg2, bg3
  );

  modport slave (
    input  vaddr,
    output fg1, fg2, fg3,
    output bg1, bg2, bg3
  );
endinterface

// File: rtl/rx78_scanout.sv
// rx78_scanout: VRAM scan-out, six planes to 24-bit RGB.
// Optional border colour: define RX78_SCANOUT_BORDER_EN.
module rx78_scanout #(
  parameter int H_BYTES = 24,
  parameter int V_LINES = 184
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cen,
  input  logic           hb,
  input  logic           vb,
  rx78_scanout_if.master vram,
  input  logic [7:0]     p1,
  input  logic [7:0]     p2,
  input  logic [7:0]     p3,
  input  logic [7:0]     p4,
  input  logic [7:0]     p5,
  input  logic [7:0]     p6,
  input  logic [7:0]     mask,
  output logic [7:0]     red,
  output logic [7:0]     green,
  output logic [7:0]     blue,
  output logic           pix_valid
);

  localparam logic [5:0]  LINE_B  = 6'(H_BYTES);
  localparam logic [7:0]  LINES   = 8'(V_LINES);
  localparam logic [12:0] LINE_B13 = 13'(H_BYTES);

  typedef enum logic [2:0] {
    BLANK, PRE0, PRE1, WAIT, ACTIVE, LINE_END
  } state_t;

  state_t state, state_nx;

  logic [12:0]     base;
  logic [12:0]     addr_q;
  logic [7:0]      ln;
  logic [5:0]      col, col_nx, col_px;
  logic [2:0]      px;
  logic [5:0][7:0] sr, sr_nx, hold, ram;
  logic            fq1, fq2;
  logic            step, reload, vld_nx;
  logic [2:0]      fc, bc;
  logic [23:0]     rgb_nx;
  logic            unused_mask;

  assign unused_mask = ^mask[7:2];
  assign vram.vaddr  = addr_q;
  assign ram = {vram.bg3, vram.bg2, vram.bg1,
                vram.fg3, vram.fg2, vram.fg1};

  always_comb begin
    state_nx = state;
    if (vb) begin
      state_nx = BLANK;
    end else begin
      unique case (state)
        BLANK, LINE_END:
          if (hb && ln < LINES) state_nx = PRE0;
        PRE0:   state_nx = PRE1;
        PRE1:   state_nx = WAIT;
        WAIT:   if (cen && !hb) state_nx = ACTIVE;
        ACTIVE: if (hb) state_nx = LINE_END;
        default: state_nx = BLANK;
      endcase
    end
  end

  // A pixel is presented only on a cen that is not lost to hb/vb.
  always_comb begin
    step   = (state == ACTIVE) && cen && !hb && !vb;
    reload = step && (px == 3'd0);
    col_nx = (col > LINE_B) ? col : col + 6'd1;
    col_px = reload ? col_nx : col;
    sr_nx  = sr;
    for (int i = 0; i < 6; i++)
      sr_nx[i] = reload ? hold[i] : {1'b0, sr[i][7:1]};
    fc = {sr_nx[2][0], sr_nx[1][0], sr_nx[0][0]};
    bc = {sr_nx[5][0], sr_nx[4][0], sr_nx[3][0]};
    vld_nx = step && (col_px != 6'd0) &&
             (col_px <= LINE_B) && (ln < LINES);
  end

  always_comb begin
    rgb_nx = '0;
    if (vld_nx) begin
      if (mask[0] && fc != 3'd0)
        rgb_nx = {{8{p1[fc]}}, {8{p2[fc]}}, {8{p3[fc]}}};
      else if (mask[1] && bc != 3'd0)
        rgb_nx = {{8{p4[bc]}}, {8{p5[bc]}}, {8{p6[bc]}}};
    end
`ifdef RX78_SCANOUT_BORDER_EN
    else if (!hb && !vb) begin
      rgb_nx = {{8{p4[0]}}, {8{p5[0]}}, {8{p6[0]}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BLANK;
      base   <= '0;
      addr_q <= '0;
      ln     <= '0;
      col    <= '0;
      px     <= '0;
      sr     <= '0;
      hold   <= '0;
      fq1    <= 1'b0;
      fq2    <= 1'b0;
    end else begin
      state <= state_nx;
      fq1   <= 1'b0;
      fq2   <= fq1;
      if (fq2) hold <= ram;
      if (state_nx == PRE0)
        addr_q <= (state == BLANK) ? 13'd0 : base;
      if (state == BLANK) begin
        ln   <= '0;
        base <= '0;
        col  <= '0;
        px   <= '0;
        sr   <= '0;
      end
      if (state == PRE1) begin
        hold <= ram;
        col  <= '0;
        px   <= '0;
        sr   <= '0;
      end
      if (state == ACTIVE && state_nx == LINE_END) begin
        base <= base + LINE_B13;
        ln   <= ln + 8'd1;
      end
      // Past the last byte the holding regs feed zeros.
      if (step) begin
        px <= px + 3'd1;
        sr <= sr_nx;
        if (reload) begin
          col <= col_nx;
          if (col_nx < LINE_B) begin
            addr_q <= base + {7'd0, col_nx};
            fq1    <= 1'b1;
          end else begin
            hold <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      pix_valid <= 1'b0;
    end else if (cen) begin
      {red, green, blue} <= rgb_nx;
      pix_valid          <= vld_nx;
    end
  end

endmodule

// File: tb/tb_rx78_scanout.sv
// tb_rx78_scanout: directed frame walk with a pixel scoreboard.
// Expected pixels come from a VRAM/palette model in the bench.
module tb_rx78_scanout;
  logic       clk = 1'b0;
  logic       reset, cen, hb, vb;
  logic [7:0] p1, p2, p3, p4, p5, p6, mask;
  logic [7:0] red, green, blue;
  logic       pix_valid;

  logic [7:0] fg1m [8192];
  logic [7:0] fg2m [8192];
  logic [7:0] fg3m [8192];
  logic [7:0] bg1m [8192];
  logic [7:0] bg2m [8192];
  logic [7:0] bg3m [8192];

  logic [24:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  rx78_scanout_if vif ();

  rx78_scanout dut (
    .clk(clk), .reset(reset), .cen(cen),
    .hb(hb), .vb(vb), .vram(vif),
    .p1(p1), .p2(p2), .p3(p3),
    .p4(p4), .p5(p5), .p6(p6),
    .mask(mask),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vif.fg1 <= fg1m[vif.vaddr];
    vif.fg2 <= fg2m[vif.vaddr];
    vif.fg3 <= fg3m[vif.vaddr];
    vif.bg1 <= bg1m[vif.vaddr];
    vif.bg2 <= bg2m[vif.vaddr];
    vif.bg3 <= bg3m[vif.vaddr];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] border_rgb();
`ifdef RX78_SCANOUT_BORDER_EN
    return {{8{p4[0]}}, {8{p5[0]}}, {8{p6[0]}}};
`else
    return 24'h0;
`endif
  endfunction

  function automatic logic [24:0] model_px(input int li, input int k);
    int a, by, bi;
    logic [2:0] f, b;
    if (k < 0) return {1'b0, border_rgb()};
    by = k / 8;
    bi = k % 8;
    if (li >= 184 || by >= 24) return {1'b0, border_rgb()};
    a = li * 24 + by;
    f = {fg3m[a][bi], fg2m[a][bi], fg1m[a][bi]};
    b = {bg3m[a][bi], bg2m[a][bi], bg1m[a][bi]};
    if (mask[0] && f != 3'd0)
      return {1'b1, {8{p1[f]}}, {8{p2[f]}}, {8{p3[f]}}};
    if (mask[1] && b != 3'd0)
      return {1'b1, {8{p4[b]}}, {8{p5[b]}}, {8{p6[b]}}};
    return {1'b1, 24'h0};
  endfunction

  task automatic pix(input int li, input int k);
    logic [24:0] obs;
    exp_q.push_back(model_px(li, k));
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    obs = {pix_valid, red, green, blue};
    chk($sformatf("pixel l%0d k%0d", li, k),
        32'(obs), 32'(exp_q.pop_front()));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic line_start(input int li, input int n);
    repeat (6) @(negedge clk);
    if (li < 184)
      chk($sformatf("prefetch l%0d", li),
          32'(vif.vaddr), 32'(li * 24));
    hb = 1'b0;
    pix(li, -1);
    for (int k = 0; k < n; k++) pix(li, k);
  endtask

  task automatic run_line(input int li, input int n);
    line_start(li, n);
    if (li < 184 && n >= 192)
      chk($sformatf("lastfetch l%0d", li),
          32'(vif.vaddr), 32'(li * 24 + 23));
    hb = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vaddr"}, 32'(vif.vaddr), 32'd0);
    chk({tag, "_red"}, 32'(red), 32'd0);
    chk({tag, "_green"}, 32'(green), 32'd0);
    chk({tag, "_blue"}, 32'(blue), 32'd0);
    chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cen = 1'b0; hb = 1'b1; vb = 1'b1;
    p1 = 8'h02; p2 = 8'h08; p3 = 8'h00;
    p4 = 8'h00; p5 = 8'h20; p6 = 8'h00;
    mask = 8'h01;
    for (int i = 0; i < 8192; i++) begin
      fg1m[i] = 8'($urandom); fg2m[i] = 8'($urandom);
      fg3m[i] = 8'($urandom); bg1m[i] = 8'($urandom);
      bg2m[i] = 8'($urandom); bg3m[i] = 8'($urandom);
    end
    fg1m[0] = 8'h01; fg2m[0] = 8'h00; fg3m[0] = 8'h00;
    bg1m[0] = 8'h00; bg2m[0] = 8'h00; bg3m[0] = 8'h00;
    for (int a = 24; a <= 72; a += 24) begin
      fg1m[a] = 8'h01; fg2m[a] = 8'h01; fg3m[a] = 8'h00;
      bg1m[a] = 8'h01; bg2m[a] = 8'h00; bg3m[a] = 8'h01;
    end

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    vb    = 1'b0;

    run_line(0, 200);
    mask = 8'h03;
    run_line(1, 200);
    mask = 8'h02;
    run_line(2, 200);
    mask = 8'h00;
    run_line(3, 40);

    mask = 8'h01;
    line_start(4, 12);
    #1 reset = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    pix(0, -1);
    pix(0, -1);
    hb = 1'b1;

    for (int l = 0; l < 3; l++) run_line(l, 200);
    for (int l = 3; l < 184; l++) run_line(l, 3);
    run_line(184, 200);
    chk("nofetch_l184", 32'(vif.vaddr), 32'(183 * 24 + 1));

    vb = 1'b1;
    repeat (3) @(negedge clk);
    p4 = 8'h01; p5 = 8'h01; p6 = 8'h01;
    vb = 1'b0;
    run_line(0, 200);

    line_start(1, 16);
    vb = 1'b1;
    repeat (2) @(negedge clk);
    hb = 1'b1;
    repeat (2) @(negedge clk);
    vb = 1'b0;
    run_line(0, 200);
    run_line(1, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
